// File: rtl/mem_line_adapter_if.sv
// Bus bundle for mem_line_adapter.
// Cache side (s_*): 128-bit line request/ack bus.
// Memory side (m_*): 16-bit word request/response bus.
// slave  : view used by the adapter (takes line requests, issues word beats).
// master : view used by the environment (issues line requests, answers beats).
interface mem_line_adapter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LINE_W = 128,
  parameter int unsigned WORD_W = 16
);
  // cache side
  logic [ADDR_W-1:0] s_adr;
  logic [LINE_W-1:0] s_dat_m;
  logic [LINE_W-1:0] s_dat_s;
  logic              s_we;
  logic              s_cyc;
  logic              s_stb;
  logic              s_ack;
  // memory side
  logic [ADDR_W-1:0] m_adr;
  logic [WORD_W-1:0] m_dat_w;
  logic [WORD_W-1:0] m_dat_r;
  logic              m_we;
  logic              m_req;
  logic              m_resp;

  modport slave (
    input  s_adr, s_dat_m, s_we, s_cyc, s_stb, m_dat_r, m_resp,
    output s_dat_s, s_ack, m_adr, m_dat_w, m_we, m_req
  );

  modport master (
    output s_adr, s_dat_m, s_we, s_cyc, s_stb, m_dat_r, m_resp,
    input  s_dat_s, s_ack, m_adr, m_dat_w, m_we, m_req
  );
endinterface

// File: rtl/mem_line_adapter.sv
// Splits a 128-bit cache line transfer into eight 16-bit memory beats.
// Ports:
//   clk    - sole clock, rising edge
//   rst_n  - synchronous active-low reset
//   bus    - slave view of mem_line_adapter_if (cache line side s_*, memory word side m_*)
// Word 0 (line bits [15:0]) goes to the lowest address. A dropped s_cyc lets the
// outstanding beat finish (DRAIN) and returns to IDLE without s_ack.
module mem_line_adapter #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_line_adapter_if.slave  bus
);

  localparam int unsigned WORD_W = 16;
  localparam int unsigned LINE_W = LINE_WORDS * WORD_W;
  localparam int unsigned CNT_W  = $clog2(LINE_WORDS);
  localparam int unsigned OFF_W  = $clog2(LINE_WORDS * 2);
  localparam int unsigned LAST   = LINE_WORDS - 1;

  typedef enum logic [1:0] {IDLE, BEAT, DRAIN, ACK} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic [LINE_W-1:0] wline_q, wline_d;
  logic [LINE_W-1:0] rline_q, rline_d;
  logic              m_req_q, m_req_d;
  logic              m_we_q, m_we_d;
  logic [ADDR_W-1:0] m_adr_q, m_adr_d;
  logic [WORD_W-1:0] m_dat_w_q, m_dat_w_d;
  logic              s_ack_q, s_ack_d;

  // Offset bits of the line address carry no information.
  logic unused_off;
  assign unused_off = ^bus.s_adr[OFF_W-1:0];

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      base_q    <= '0;
      we_q      <= 1'b0;
      wline_q   <= '0;
      rline_q   <= '0;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_adr_q   <= '0;
      m_dat_w_q <= '0;
      s_ack_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      base_q    <= base_d;
      we_q      <= we_d;
      wline_q   <= wline_d;
      rline_q   <= rline_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_adr_q   <= m_adr_d;
      m_dat_w_q <= m_dat_w_d;
      s_ack_q   <= s_ack_d;
    end
  end

  // Next state; output registers are loaded with the values for the next cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    we_d      = we_q;
    wline_d   = wline_q;
    rline_d   = rline_q;
    m_req_d   = 1'b0;
    m_we_d    = 1'b0;
    m_adr_d   = m_adr_q;
    m_dat_w_d = m_dat_w_q;
    s_ack_d   = 1'b0;
    cnt_inc   = cnt_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.s_cyc && bus.s_stb) begin
          base_d    = {bus.s_adr[ADDR_W-1:OFF_W], OFF_W'(0)};
          we_d      = bus.s_we;
          wline_d   = bus.s_dat_m;
          cnt_d     = '0;
          state_d   = BEAT;
          m_req_d   = 1'b1;
          m_we_d    = bus.s_we;
          m_adr_d   = {bus.s_adr[ADDR_W-1:OFF_W], OFF_W'(0)};
          m_dat_w_d = bus.s_dat_m[WORD_W-1:0];
        end
      end

      BEAT: begin
        m_req_d = 1'b1;
        m_we_d  = we_q;
        if (bus.m_resp) begin
          if (!we_q) rline_d[cnt_q*WORD_W +: WORD_W] = bus.m_dat_r;
          if (!bus.s_cyc) begin
            // beat completed together with the abort: nothing left to drain
            state_d = IDLE;
            cnt_d   = '0;
            m_req_d = 1'b0;
            m_we_d  = 1'b0;
          end else if (cnt_q == CNT_W'(LAST)) begin
            state_d = ACK;
            cnt_d   = '0;
            m_req_d = 1'b0;
            m_we_d  = 1'b0;
            s_ack_d = 1'b1;
          end else begin
            cnt_d     = cnt_inc;
            m_adr_d   = base_q + ADDR_W'({cnt_inc, 1'b0});
            m_dat_w_d = wline_q[cnt_inc*WORD_W +: WORD_W];
          end
        end else if (!bus.s_cyc) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        m_req_d = 1'b1;
        m_we_d  = we_q;
        if (bus.m_resp) begin
          if (!we_q) rline_d[cnt_q*WORD_W +: WORD_W] = bus.m_dat_r;
          state_d = IDLE;
          cnt_d   = '0;
          m_req_d = 1'b0;
          m_we_d  = 1'b0;
        end
      end

      ACK: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.s_dat_s = rline_q;
  assign bus.s_ack   = s_ack_q;
  assign bus.m_req   = m_req_q;
  assign bus.m_we    = m_we_q;
  assign bus.m_adr   = m_adr_q;
  assign bus.m_dat_w = m_dat_w_q;

endmodule

// File: tb/tb_mem_line_adapter.sv
// Directed bench for mem_line_adapter: memory responder with programmable
// wait states (read word = its address), beat/ack logger, directed steps.
module tb_mem_line_adapter;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   delay  = 0;

  mem_line_adapter_if bus ();

  mem_line_adapter #(.LINE_WORDS(8), .ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: answers after `delay` wait cycles, data = address.
  logic [3:0] wcnt = '0;
  assign bus.m_resp  = bus.m_req && (int'(wcnt) == delay);
  assign bus.m_dat_r = bus.m_adr;

  // Beat / ack log and stability monitor.
  logic [15:0] b_adr [64];
  logic [15:0] b_dat [64];
  logic        b_we  [64];
  int          nb = 0;
  int          nack = 0;
  int          unstable = 0;
  logic        pend = 1'b0;
  logic [15:0] pa, pd;
  logic        pw;

  always @(posedge clk) begin
    if (!rst_n || !bus.m_req || bus.m_resp) wcnt <= '0;
    else wcnt <= wcnt + 4'd1;
    if (rst_n && bus.m_req && bus.m_resp) begin
      if (nb < 64) begin
        b_adr[nb] <= bus.m_adr;
        b_dat[nb] <= bus.m_dat_w;
        b_we[nb]  <= bus.m_we;
      end
      nb <= nb + 1;
    end
    if (rst_n && bus.s_ack) nack <= nack + 1;
    if (pend && rst_n &&
        (!bus.m_req || bus.m_adr != pa || bus.m_dat_w != pd || bus.m_we != pw))
      unstable <= unstable + 1;
    pend <= rst_n && bus.m_req && !bus.m_resp;
    pa   <= bus.m_adr;
    pd   <= bus.m_dat_w;
    pw   <= bus.m_we;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Cycles from the request cycle until s_ack is seen; -1 on timeout.
  task automatic wait_ack(output int n);
    n = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (bus.s_ack) begin
        n = i + 1;
        return;
      end
    end
  endtask

  // Wait until `k` beats have completed since beat index n0; false on timeout.
  task automatic wait_beats(input int n0, input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (nb - n0 >= k) begin
        ok = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic request(input logic [15:0] adr, input logic we, input logic [127:0] dat);
    bus.s_adr   = adr;
    bus.s_we    = we;
    bus.s_dat_m = dat;
    bus.s_cyc   = 1'b1;
    bus.s_stb   = 1'b1;
  endtask

  task automatic release_bus();
    bus.s_cyc = 1'b0;
    bus.s_stb = 1'b0;
  endtask

  initial begin
    int n0, a0, u0, lat;
    bit ok;
    logic [127:0] w_line;

    rst_n       = 1'b0;
    bus.s_adr   = '0;
    bus.s_dat_m = '0;
    bus.s_we    = 1'b0;
    bus.s_cyc   = 1'b0;
    bus.s_stb   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // reset values
    chk("rst_s_ack",   128'(bus.s_ack),   128'(0));
    chk("rst_s_dat_s", bus.s_dat_s,       128'(0));
    chk("rst_m_req",   128'(bus.m_req),   128'(0));
    chk("rst_m_we",    128'(bus.m_we),    128'(0));
    chk("rst_m_adr",   128'(bus.m_adr),   128'(0));
    chk("rst_m_dat_w", 128'(bus.m_dat_w), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // zero-wait read of line 1230 (s_adr offset bits ignored)
    n0 = nb; a0 = nack;
    request(16'h1236, 1'b0, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98);
    wait_ack(lat);
    release_bus();
    chk("rd_latency", 128'(lat), 128'(9));
    chk("rd_beats",   128'(nb - n0), 128'(8));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rd_adr%0d", i), 128'(b_adr[n0+i]), 128'(16'h1230 + 16'(2*i)));
      chk($sformatf("rd_we%0d", i),  128'(b_we[n0+i]),  128'(0));
    end
    chk("rd_line", bus.s_dat_s, 128'h123E_123C_123A_1238_1236_1234_1232_1230);
    @(posedge clk); #1;
    chk("rd_ack_one_cycle", 128'(bus.s_ack), 128'(0));
    chk("rd_req_low",       128'(bus.m_req), 128'(0));
    chk("rd_ack_count",     128'(nack - a0), 128'(1));

    // zero-wait write of line 2000; fill buffer must not change
    n0 = nb; a0 = nack;
    w_line = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
    request(16'h2000, 1'b1, w_line);
    wait_ack(lat);
    release_bus();
    chk("wr_latency", 128'(lat), 128'(9));
    chk("wr_beats",   128'(nb - n0), 128'(8));
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wr_adr%0d", i), 128'(b_adr[n0+i]), 128'(16'h2000 + 16'(2*i)));
      chk($sformatf("wr_dat%0d", i), 128'(b_dat[n0+i]), 128'(16'(i * 16'h1111)));
      chk($sformatf("wr_we%0d", i),  128'(b_we[n0+i]),  128'(1));
    end
    chk("wr_line_kept", bus.s_dat_s, 128'h123E_123C_123A_1238_1236_1234_1232_1230);
    @(posedge clk); #1;
    chk("wr_ack_count", 128'(nack - a0), 128'(1));

    // read with three wait cycles per beat
    delay = 3;
    u0 = unstable;
    request(16'h4A58, 1'b0, '0);
    wait_ack(lat);
    release_bus();
    chk("slow_latency", 128'(lat), 128'(33));
    chk("slow_stable",  128'(unstable - u0), 128'(0));
    chk("slow_line", bus.s_dat_s, 128'h4A5E_4A5C_4A5A_4A58_4A56_4A54_4A52_4A50);
    @(posedge clk); #1;

    // write aborted during beat 3 with two wait cycles per beat
    delay = 2;
    n0 = nb; a0 = nack;
    request(16'h3000, 1'b1, 128'hAAAA_9999_8888_7777_6666_5555_4444_3333);
    wait_beats(n0, 3, ok);
    chk("abort_reach_beat3", 128'(ok), 128'(1));
    chk("abort_beat3_adr",   128'(bus.m_adr), 128'(16'h3006));
    release_bus();
    @(posedge clk); #1;
    chk("abort_drain_req", 128'(bus.m_req), 128'(1));
    chk("abort_drain_adr", 128'(bus.m_adr), 128'(16'h3006));
    repeat (12) @(posedge clk);
    #1;
    chk("abort_beats",    128'(nb - n0),    128'(4));
    chk("abort_last_dat", 128'(b_dat[n0+3]), 128'(16'h6666));
    chk("abort_no_ack",   128'(nack - a0),  128'(0));
    chk("abort_req_low",  128'(bus.m_req),  128'(0));

    // next request after the abort is served normally
    delay = 0;
    request(16'h0100, 1'b0, '0);
    wait_ack(lat);
    release_bus();
    chk("post_abort_latency", 128'(lat), 128'(9));
    chk("post_abort_line", bus.s_dat_s, 128'h010E_010C_010A_0108_0106_0104_0102_0100);
    @(posedge clk); #1;

    // reset during beat 5
    n0 = nb; a0 = nack;
    request(16'h5000, 1'b0, '0);
    wait_beats(n0, 5, ok);
    chk("mid_reach_beat5", 128'(ok), 128'(1));
    rst_n = 1'b0;
    release_bus();
    @(posedge clk); #1;
    chk("mid_rst_s_ack",   128'(bus.s_ack),   128'(0));
    chk("mid_rst_m_req",   128'(bus.m_req),   128'(0));
    chk("mid_rst_s_dat_s", bus.s_dat_s,       128'(0));
    chk("mid_rst_m_adr",   128'(bus.m_adr),   128'(0));
    chk("mid_rst_m_we",    128'(bus.m_we),    128'(0));
    chk("mid_rst_m_dat_w", 128'(bus.m_dat_w), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_no_ack", 128'(nack - a0), 128'(0));

    // line at top of address space: no carry out of the word address
    n0 = nb;
    request(16'hFFF0, 1'b0, '0);
    wait_ack(lat);
    release_bus();
    chk("top_latency", 128'(lat), 128'(9));
    for (int i = 0; i < 8; i++)
      chk($sformatf("top_adr%0d", i), 128'(b_adr[n0+i]), 128'(16'hFFF0 + 16'(2*i)));
    chk("top_line", bus.s_dat_s, 128'hFFFE_FFFC_FFFA_FFF8_FFF6_FFF4_FFF2_FFF0);
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
